// File: rtl/spi_flash_responder.sv
// SPI flash responder: emulates a serial flash on oversampled SPI pins (mode 0).
// Supports READ (0x03) and JEDEC ID (0x9F). Data is streamed from a synchronous
// byte-wide memory read port.
// Optional: define SPI_FLASH_RESP_FAST_READ_EN to accept FAST READ (0x0B), which
// adds 8 dummy clocks between the address and the data.
module spi_flash_responder #(
  parameter int unsigned W_ADDR   = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic [W_ADDR-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [7:0]        mem_rdata
);

`ifdef SPI_FLASH_RESP_FAST_READ_EN
  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StId, StIgnore, StDummy} state_e;
`else
  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StId, StIgnore} state_e;
`endif

  logic [1:0] sclk_sync_q, cs_sync_q, sdi_sync_q;
  logic       sclk_prev_q;
  logic       sclk_s, cs_n_s, sdi_s, sclk_rise, sclk_fall;

  // Two-flop synchronisers plus a third flop on sclk for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sdi_sync_q  <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      sdi_sync_q  <= {sdi_sync_q[0], spi_sdi};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign cs_n_s    = cs_sync_q[1];
  assign sdi_s     = sdi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [22:0]       in_sr_q, in_sr_d;
  logic [6:0]        out_sr_q, out_sr_d;
  logic              byte_done_q, byte_done_d;   // next sclk fall loads a fresh byte
  logic [1:0]        id_idx_q, id_idx_d;
  logic              sdo_q, sdo_d, oe_q, oe_d;
  logic [W_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic              mem_ren_q, mem_ren_d, ren_dly_q;
  logic [7:0]        rdata_q, rdata_d;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
  logic              fast_q, fast_d;
`endif

  logic [7:0]  cmd_byte, id_byte, load_byte;
  logic [23:0] addr_full;

  assign cmd_byte  = {in_sr_q[6:0], sdi_s};
  assign addr_full = {in_sr_q, sdi_s};

  // Select the outgoing JEDEC byte; zeros once all three have been sent
  always_comb begin
    id_byte = 8'h00;
    unique case (id_idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
    load_byte = (state_q == StData) ? rdata_q : id_byte;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      in_sr_q     <= '0;
      out_sr_q    <= '0;
      byte_done_q <= 1'b0;
      id_idx_q    <= '0;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_ren_q   <= 1'b0;
      ren_dly_q   <= 1'b0;
      rdata_q     <= '0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      in_sr_q     <= in_sr_d;
      out_sr_q    <= out_sr_d;
      byte_done_q <= byte_done_d;
      id_idx_q    <= id_idx_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_ren_q   <= mem_ren_d;
      ren_dly_q   <= mem_ren_q;
      rdata_q     <= rdata_d;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
      fast_q      <= fast_d;
`endif
    end
  end

  // Next-state: command decode, address capture, byte load/shift-out
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    in_sr_d     = in_sr_q;
    out_sr_d    = out_sr_q;
    byte_done_d = byte_done_q;
    id_idx_d    = id_idx_q;
    sdo_d       = sdo_q;
    oe_d        = oe_q;
    mem_addr_d  = mem_addr_q;
    mem_ren_d   = 1'b0;
    // Memory data arrives the cycle after the read strobe
    rdata_d     = ren_dly_q ? mem_rdata : rdata_q;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    fast_d      = fast_q;
`endif

    if (cs_n_s) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      sdo_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d   = StCmd;
          bit_cnt_d = '0;
        end
        StCmd: begin
          if (sclk_rise) begin
            in_sr_d   = addr_full[22:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              case (cmd_byte)
                8'h03: begin
                  state_d = StAddr;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                  fast_d  = 1'b0;
`endif
                end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                8'h0B: begin
                  state_d = StAddr;
                  fast_d  = 1'b1;
                end
`endif
                8'h9F: begin
                  state_d     = StId;
                  byte_done_d = 1'b1;
                  id_idx_d    = '0;
                end
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (sclk_rise) begin
            in_sr_d   = addr_full[22:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d   = '0;
              mem_addr_d  = addr_full[W_ADDR-1:0];
              mem_ren_d   = 1'b1;
              byte_done_d = 1'b1;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
              state_d     = fast_q ? StDummy : StData;
`else
              state_d     = StData;
`endif
            end
          end
        end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
        StDummy: begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              state_d   = StData;
            end
          end
        end
`endif
        StData, StId: begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d   = '0;
              byte_done_d = 1'b1;
            end
          end else if (sclk_fall) begin
            if (byte_done_q) begin
              sdo_d       = load_byte[7];
              out_sr_d    = load_byte[6:0];
              oe_d        = 1'b1;
              byte_done_d = 1'b0;
              if (state_q == StData) begin
                // Prefetch the next byte while this one shifts out
                mem_addr_d = mem_addr_q + W_ADDR'(1);
                mem_ren_d  = 1'b1;
              end else if (id_idx_q != 2'd3) begin
                id_idx_d = id_idx_q + 2'd1;
              end
            end else begin
              sdo_d    = out_sr_q[6];
              out_sr_d = {out_sr_q[5:0], 1'b0};
            end
          end
        end
        StIgnore: begin
          oe_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = oe_q;
  assign mem_addr   = mem_addr_q;
  assign mem_ren    = mem_ren_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a 16-bit-address instance and an
// 8-bit-address instance share the SPI pins, each backed by its own memory.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_sdi = 1'b0;
  logic        sdo_a, oe_a, ren_a, sdo_b, oe_b, ren_b;
  logic [15:0] addr_a;
  logic [7:0]  addr_b;
  logic [7:0]  rdata_a = 8'h00, rdata_b = 8'h00;
  logic [7:0]  mem_a [65536];
  logic [7:0]  mem_b [256];

  int checks = 0;
  int errors = 0;
  int ren_cnt_a = 0, ren_cnt_b = 0, oe_cnt_a = 0, oe_cnt_b = 0;
  int ren0_a, ren0_b, oe0_a, oe0_b;
  logic [7:0] rx_a, rx_b;

  always #5 clk = ~clk;

  spi_flash_responder #(.W_ADDR(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_sdi(spi_sdi),
    .spi_sdo(sdo_a), .spi_sdo_oe(oe_a), .mem_addr(addr_a), .mem_ren(ren_a),
    .mem_rdata(rdata_a)
  );

  spi_flash_responder #(.W_ADDR(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_sdi(spi_sdi),
    .spi_sdo(sdo_b), .spi_sdo_oe(oe_b), .mem_addr(addr_b), .mem_ren(ren_b),
    .mem_rdata(rdata_b)
  );

  // Synchronous memories and activity counters
  always @(posedge clk) begin
    if (ren_a) rdata_a <= mem_a[addr_a];
    if (ren_b) rdata_b <= mem_b[addr_b];
    if (ren_a) ren_cnt_a++;
    if (ren_b) ren_cnt_b++;
    if (oe_a) oe_cnt_a++;
    if (oe_b) oe_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift nbits of tx MSB-first; sclk half period = 8 clk
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] ra, output logic [7:0] rb);
    ra = 8'h00;
    rb = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_sdi = tx[i];
      #80;
      spi_sclk = 1'b1;
      ra[i] = sdo_a;
      rb[i] = sdo_b;
      #80;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80;
    spi_cs_n = 1'b1;
    #160;
  endtask

  task automatic snap();
    ren0_a = ren_cnt_a;
    ren0_b = ren_cnt_b;
    oe0_a  = oe_cnt_a;
    oe0_b  = oe_cnt_b;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
    mem_a[16'h0010] = 8'hA5;
    mem_a[16'h0011] = 8'h3C;
    mem_a[16'h0020] = 8'h77;
    mem_b[8'h20]    = 8'h66;
    mem_b[8'hFF]    = 8'h11;
    mem_b[8'h00]    = 8'h22;

    repeat (4) @(negedge clk);
    check("reset_sdo", {31'd0, sdo_a}, 32'd0);
    check("reset_oe", {31'd0, oe_a}, 32'd0);
    check("reset_ren", {31'd0, ren_a}, 32'd0);
    check("reset_addr_a", {16'd0, addr_a}, 32'd0);
    check("reset_addr_b", {24'd0, addr_b}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // READ at 0x000010
    snap();
    cs_low();
    xfer(8'h03, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    xfer(8'h10, 8, rx_a, rx_b);
    check("read_oe_low_in_hdr", oe_cnt_a - oe0_a, 0);
    check("read_ren_after_addr", ren_cnt_a - ren0_a, 1);
    xfer(8'hFF, 8, rx_a, rx_b);
    check("read_byte0", {24'd0, rx_a}, 32'hA5);
    check("read_oe_high", {31'd0, oe_a}, 32'd1);
    xfer(8'hFF, 8, rx_a, rx_b);
    check("read_byte1", {24'd0, rx_a}, 32'h3C);
    cs_high();
    check("read_oe_after_cs", {31'd0, oe_a}, 32'd0);
    check("read_ren_total", ren_cnt_a - ren0_a, 4);
    check("read_addr_final", {16'd0, addr_a}, 32'h0013);

    // JEDEC ID
    snap();
    cs_low();
    xfer(8'h9F, 8, rx_a, rx_b);
    check("jedec_oe_low_in_cmd", oe_cnt_a - oe0_a, 0);
    xfer(8'h00, 8, rx_a, rx_b);
    check("jedec_b0", {24'd0, rx_a}, 32'hEF);
    xfer(8'h00, 8, rx_a, rx_b);
    check("jedec_b1", {24'd0, rx_a}, 32'h40);
    xfer(8'h00, 8, rx_a, rx_b);
    check("jedec_b2", {24'd0, rx_a}, 32'h16);
    xfer(8'h00, 8, rx_a, rx_b);
    check("jedec_b3", {24'd0, rx_a}, 32'h00);
    cs_high();
    check("jedec_no_ren", ren_cnt_a - ren0_a, 0);

    // Unknown command
    snap();
    cs_low();
    xfer(8'h55, 8, rx_a, rx_b);
    xfer(8'hFF, 8, rx_a, rx_b);
    xfer(8'hFF, 8, rx_a, rx_b);
    cs_high();
    check("unk_oe_a", oe_cnt_a - oe0_a, 0);
    check("unk_ren_a", ren_cnt_a - ren0_a, 0);
    check("unk_oe_b", oe_cnt_b - oe0_b, 0);
    check("unk_ren_b", ren_cnt_b - ren0_b, 0);

    // Abort after 12 address bits, then a clean READ of 0x000020
    snap();
    cs_low();
    xfer(8'h03, 8, rx_a, rx_b);
    xfer(8'hAB, 8, rx_a, rx_b);
    xfer(8'hA0, 4, rx_a, rx_b);
    cs_high();
    check("abort_ren", ren_cnt_a - ren0_a, 0);
    check("abort_oe", oe_cnt_a - oe0_a, 0);
    cs_low();
    xfer(8'h03, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    xfer(8'h20, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    check("abort_read_a", {24'd0, rx_a}, 32'h77);
    check("abort_read_b", {24'd0, rx_b}, 32'h66);
    cs_high();

    // Address wrap on the 8-bit instance
    cs_low();
    xfer(8'h03, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    xfer(8'hFF, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    check("wrap_byte0", {24'd0, rx_b}, 32'h11);
    xfer(8'h00, 8, rx_a, rx_b);
    check("wrap_byte1", {24'd0, rx_b}, 32'h22);
    cs_high();
    check("wrap_addr_b", {24'd0, addr_b}, 32'h02);

    // FAST READ
    snap();
    cs_low();
    xfer(8'h0B, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    xfer(8'h10, 8, rx_a, rx_b);
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    check("fast_ren_after_addr", ren_cnt_a - ren0_a, 1);
    xfer(8'h00, 8, rx_a, rx_b);
    check("fast_oe_low_dummy", oe_cnt_a - oe0_a, 0);
    xfer(8'h00, 8, rx_a, rx_b);
    check("fast_byte0", {24'd0, rx_a}, 32'hA5);
    cs_high();
`else
    xfer(8'h00, 8, rx_a, rx_b);
    xfer(8'h00, 8, rx_a, rx_b);
    cs_high();
    check("fast_dis_oe", oe_cnt_a - oe0_a, 0);
    check("fast_dis_ren", ren_cnt_a - ren0_a, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
